// File: rtl/dmem_byte_seq_if.sv
// Request/response and byte-RAM port bundle for dmem_byte_seq.
// The master side is the core plus the RAM; the slave side is the sequencer.
interface dmem_byte_seq_if #(
    parameter int ADDR_WIDTH = 13
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [1:0]            req_size;
    logic                  req_signed;
    logic [ADDR_WIDTH-3:0] req_addr;
    logic [31:0]           req_wdata;
    logic                  rsp_valid;
    logic [31:0]           rsp_rdata;
    logic                  rsp_err;
    logic [ADDR_WIDTH-1:0] mem_w_addr;
    logic [ADDR_WIDTH-1:0] mem_r_addr;
    logic                  mem_write_en;
    logic                  mem_read_en;
    logic [7:0]            mem_din;
    logic [7:0]            mem_dout;

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_dout,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_w_addr, mem_r_addr, mem_write_en, mem_read_en, mem_din
    );

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_dout,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_w_addr, mem_r_addr, mem_write_en, mem_read_en, mem_din
    );
endinterface

// File: rtl/dmem_byte_seq.sv
// Serialises 32-bit loads/stores into single-byte RAM accesses, little-endian.
// Optional MISALIGN_CHECK_EN: reject misaligned half/word accesses with rsp_err.
module dmem_byte_seq #(
    parameter int ADDR_WIDTH = 13
) (
    input logic           clk,
    input logic           rst_n,
    dmem_byte_seq_if.slave bus
);
    localparam int IW = ADDR_WIDTH - 2;

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t        state, next_state;
    logic [1:0]    cnt;
    logic [1:0]    last;
    logic          we_q;
    logic          signed_q;
    logic [IW-1:0] addr_q;
    logic [IW-1:0] byte_idx;
    logic [31:0]   wdata_q;
    logic [23:0]   rbuf;
    logic          rsp_valid_q;
    logic [31:0]   rdata_q;
    logic [31:0]   load_word;
    logic [1:0]    req_last;
    logic          accept;
    logic          last_beat;
    logic          misaligned;

    assign accept    = (state == IDLE) && bus.req_valid;
    assign last_beat = (state == ACCESS) && (cnt == last);

    // Index of the final byte: 0 for byte, 1 for half, 3 for word (size 11 included).
    always_comb begin
        case (bus.req_size)
            2'b00:   req_last = 2'd0;
            2'b01:   req_last = 2'd1;
            default: req_last = 2'd3;
        endcase
    end

`ifdef MISALIGN_CHECK_EN
    logic err_q;

    assign misaligned = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                        (bus.req_size[1] && (bus.req_addr[1:0] != 2'b00));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= accept && misaligned;
    end

    assign bus.rsp_err = err_q;
`else
    assign misaligned  = 1'b0;
    assign bus.rsp_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        next_state       = state;
        bus.mem_write_en = 1'b0;
        bus.mem_read_en  = 1'b0;
        case (state)
            IDLE: begin
                if (accept && !misaligned) next_state = ACCESS;
            end
            ACCESS: begin
                bus.mem_write_en = we_q;
                bus.mem_read_en  = !we_q;
                if (last_beat) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign byte_idx       = addr_q + IW'(cnt);
    assign bus.mem_w_addr = {byte_idx, 2'b00};
    assign bus.mem_r_addr = {byte_idx, 2'b00};
    assign bus.mem_din    = wdata_q[{cnt, 3'b000} +: 8];
    assign bus.req_ready  = (state == IDLE);
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_rdata  = rdata_q;

    // The final byte bypasses rbuf and comes straight from the RAM output.
    always_comb begin
        case (last)
            2'd0:    load_word = {{24{signed_q & bus.mem_dout[7]}}, bus.mem_dout};
            2'd1:    load_word = {{16{signed_q & bus.mem_dout[7]}}, bus.mem_dout, rbuf[7:0]};
            default: load_word = {bus.mem_dout, rbuf};
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            last        <= '0;
            we_q        <= 1'b0;
            signed_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rbuf        <= '0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            if (accept) begin
                cnt      <= '0;
                last     <= req_last;
                we_q     <= bus.req_we;
                signed_q <= bus.req_signed;
                addr_q   <= bus.req_addr;
                wdata_q  <= bus.req_wdata;
                if (misaligned) rsp_valid_q <= 1'b1;
            end
            if (state == ACCESS) begin
                if (last_beat) begin
                    rsp_valid_q <= 1'b1;
                    if (!we_q) rdata_q <= load_word;
                end else begin
                    cnt <= cnt + 2'd1;
                    if (!we_q) rbuf[{cnt, 3'b000} +: 8] <= bus.mem_dout;
                end
            end
        end
    end
endmodule

// File: doc/dmem_byte_seq.md
# dmem_byte_seq

Load/store sequencer between the core's MEM stage and the byte-wide data RAM. Accepts one 32-bit load or store per handshake (byte, half or word, little-endian) and serialises it into consecutive single-byte RAM accesses. Loads are reassembled and sign- or zero-extended, and each access completes with a one-cycle response pulse.

## Interface
Parameters:
- ADDR_WIDTH, 13, RAM port address width; the byte index occupies bits [ADDR_WIDTH-1:2].

Ports:
- CLK  in  1  single clock; sequencer logic on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- REQ_VALID  in  1  request present.
- REQ_READY  out  1  sequencer can accept; high only in IDLE.
- REQ_WE  in  1  1 = store, 0 = load.
- REQ_SIZE  in  2  00 = byte, 01 = half, 10 = word, 11 = treated as word.
- REQ_SIGNED  in  1  sign-extend a load (byte/half only).
- REQ_ADDR  in  ADDR_WIDTH-2  byte address.
- REQ_WDATA  in  32  store data.
- RSP_VALID  out  1  one-cycle completion pulse.
- RSP_RDATA  out  32  load result; held until the next completion.
- RSP_ERR  out  1  misaligned reject, qualified by RSP_VALID (see Configuration).
- MEM_W_ADDR  out  ADDR_WIDTH  write address, {byte index, 2'b00}.
- MEM_R_ADDR  out  ADDR_WIDTH  read address, same value as MEM_W_ADDR.
- MEM_WRITE_EN  out  1  RAM write strobe.
- MEM_READ_EN  out  1  RAM read strobe.
- MEM_DIN  out  8  byte to RAM.
- MEM_DOUT  in  8  byte from RAM.

## Operation
- The RAM samples its inputs on the falling edge of CLK. Read data registered at that falling edge is valid at the following rising edge.
- FSM states:
  - IDLE: REQ_READY = 1. On REQ_VALID & REQ_READY, latch WE, size, signed, address and WDATA, set N = 1/2/4 bytes, set k = 0, go to ACCESS.
  - ACCESS: drive byte k. Address = REQ_ADDR + k, modulo 2^(ADDR_WIDTH-2), so accesses wrap at the top of the address space.
    - Store: MEM_WRITE_EN = 1, MEM_DIN = WDATA[8k+7:8k].
    - Load: MEM_READ_EN = 1. Byte k is captured from MEM_DOUT at the next rising edge into result bits [8k+7:8k].
  - After byte N-1 is issued, go to IDLE and pulse RSP_VALID.
- Load result for byte/half: upper bits = sign bit when REQ_SIGNED, else 0. RSP_RDATA is written only on a load completion.
- A store completion pulses RSP_VALID; RSP_RDATA is unchanged.
- RSP_ERR = 0 on every completion except a misaligned reject.
- There is no response backpressure; the consumer must take RSP_VALID when it occurs.
- MEM_WRITE_EN and MEM_READ_EN are never high together. Both are 0 outside ACCESS.

## Timing
- Reset (async assert, sync deassert): state IDLE, REQ_READY = 1, RSP_VALID = 0, RSP_ERR = 0, RSP_RDATA = 0, MEM_* outputs = 0.
- Handshake at rising edge E:
  - MEM strobes for byte k are high in the cycle following edge E+k, for k = 0..N-1.
  - Load byte k is captured at edge E+k+1. The last byte is taken directly from MEM_DOUT at edge E+N.
  - RSP_VALID is high in the cycle after edge E+N, for both loads and stores.
- Latency from handshake to response: byte 1, half 2, word 4 cycles.
- REQ_READY is low from edge E until edge E+N. The earliest next handshake is edge E+N+1, giving N+1 cycles per access.
- Reset mid-access aborts the transfer immediately and no response is issued. A partially completed store leaves the bytes already written in RAM.

## Configuration
- MISALIGN_CHECK_EN defined:
  - A half access with REQ_ADDR[0] = 1, or a word access with REQ_ADDR[1:0] != 0, is rejected.
  - No MEM strobes are issued. RSP_VALID = 1 and RSP_ERR = 1 in the cycle after the handshake edge, and RSP_RDATA is unchanged.
- MISALIGN_CHECK_EN undefined: any byte address is accepted, with wrap-around. RSP_ERR is tied to 0.

## Test plan
- Word store 0xDEADBEEF at address 0x10, then word load from 0x10:
  - Store writes RAM bytes 0x10..0x13 = EF, BE, AD, DE.
  - Load returns RSP_RDATA = 0xDEADBEEF, with RSP_VALID 4 cycles after the handshake.
- Byte load from a location holding 0x80:
  - Signed → 0xFFFFFF80; unsigned → 0x00000080.
  - RSP_VALID 1 cycle after the handshake.
- Half store 0x1234 at address 0x7FF (top of a 2^11 space):
  - Bytes 34 → 0x7FF and 12 → 0x000 (wrap-around).
  - With MISALIGN_CHECK_EN instead: RSP_ERR = 1 and no MEM_WRITE_EN.
- Back-to-back word loads with REQ_VALID held high:
  - Handshakes 5 cycles apart; REQ_READY low for 4 cycles each.
  - MEM_READ_EN never coincides with MEM_WRITE_EN.
- RST_N asserted after 2 bytes of a word store:
  - All outputs go to reset values asynchronously and no RSP_VALID is issued.
  - RAM holds only the first 2 new bytes; REQ_READY = 1 after reset release.
